// File: rtl/edge_pulse_tx_if.sv
// edge_pulse_tx_if
//   Bundles the event request and status signals of edge_pulse_tx.
//   Macro that affects the attached design: EDGE_PULSE_TX_PULSE_MODE_EN (see edge_pulse_tx.sv).
// Signals
//   pulse_in  event request, one event per high cycle (driven by master)
//   sig_out   line level towards the remote edge_detect (driven by slave)
//   busy      transmitter active or backlog non-empty
//   pending   events accepted but not yet transmitted
//   overflow  sticky dropped-event flag
// Modports
//   master    the event source (drives pulse_in, observes status)
//   slave     the transmitter (edge_pulse_tx)
interface edge_pulse_tx_if #(
    parameter int PEND_W = 3
);
    logic              pulse_in;
    logic              sig_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output pulse_in,
        input  sig_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        output sig_out,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/edge_pulse_tx.sv
// edge_pulse_tx
//   Transmit side of the single-wire edge protocol. One-cycle event requests
//   become transitions on the registered level line sig_out, each held stable
//   for MIN_HOLD cycles so a 3-flop resync receiver catches every one. Bursts
//   queue in a saturating backlog counter and are paced out.
//   Optional macro EDGE_PULSE_TX_PULSE_MODE_EN: each event becomes a full high
//   pulse (MIN_HOLD high, MIN_HOLD low) instead of a single toggle.
// Ports
//   clk       single clock, posedge
//   reset     synchronous, active-high; aborts activity and drops the backlog
//   bus       edge_pulse_tx_if.slave: pulse_in in; sig_out, busy, pending,
//             overflow out
// Parameters
//   MIN_HOLD  cycles sig_out stays stable after each transition (3..255)
//   PEND_W    backlog counter width, max backlog 2**PEND_W-1
//
// state   | meaning
// IDLE    | line quiet, next event transmitted immediately
// HOLD    | (toggle mode) holding the last transition for MIN_HOLD cycles
// HIGH    | (pulse mode) line high for MIN_HOLD cycles
// GAP     | (pulse mode) line low for MIN_HOLD cycles before the next pulse
module edge_pulse_tx #(
    parameter int MIN_HOLD = 4,
    parameter int PEND_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    edge_pulse_tx_if.slave   bus
);
    localparam int                CNT_W    = $clog2(MIN_HOLD);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MIN_HOLD - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

`ifdef EDGE_PULSE_TX_PULSE_MODE_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
`else
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
`endif

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [PEND_W-1:0] pending;
    logic              sig;
    logic              overflow;
    logic              work;
    logic              slot;
    logic              consume;

    assign work = bus.pulse_in || (pending != '0);

    // slot: the FSM is ready to start a new event this cycle
`ifdef EDGE_PULSE_TX_PULSE_MODE_EN
    assign slot = (state == ST_IDLE) || ((state == ST_GAP) && (cnt == '0));
`else
    assign slot = (state == ST_IDLE) || ((state == ST_HOLD) && (cnt == '0));
`endif
    assign consume = slot && work;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sig      <= 1'b0;
        end else begin
            case (state)
`ifdef EDGE_PULSE_TX_PULSE_MODE_EN
                ST_IDLE: begin
                    if (work) begin
                        sig   <= 1'b1;
                        cnt   <= CNT_LOAD;
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        sig   <= 1'b0;
                        cnt   <= CNT_LOAD;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (work) begin
                        sig   <= 1'b1;
                        cnt   <= CNT_LOAD;
                        state <= ST_HIGH;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
`else
                ST_IDLE: begin
                    if (work) begin
                        sig   <= ~sig;
                        cnt   <= CNT_LOAD;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (work) begin
                        sig <= ~sig;
                        cnt <= CNT_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Backlog: an arriving event consumed in the same cycle never touches
    // pending. consume without arrive implies pending!=0, so no underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (bus.pulse_in && !consume) begin
            if (pending == PEND_MAX) begin
                overflow <= 1'b1;
            end else begin
                pending <= pending + PEND_W'(1);
            end
        end else if (!bus.pulse_in && consume) begin
            pending <= pending - PEND_W'(1);
        end
    end

    assign bus.sig_out  = sig;
    assign bus.pending  = pending;
    assign bus.overflow = overflow;
    assign bus.busy     = (state != ST_IDLE) || (pending != '0);
endmodule
